spin_broadcast_buffer: RTL

Parametrised broadcast buffer for spin vectors. It replaces the hard-wired AND-join between the analog-wrap spin output and its consumers (energy monitor, flip manager) with an N-port fan-out that has per-port decoupling storage. One producer writes spin words into a shared DEPTH-entry store. Each enabled consumer port reads every word exactly once, either in lockstep with the other ports or independently.

---
 rtl/lagd_spin_pkg.sv | 12 +
 rtl/spin_broadcast_rdport.sv | 65 ++++++
 rtl/spin_broadcast_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lagd_spin_pkg.sv
// Shared types and encodings for the spin broadcast buffer.
// The mode constants are used by the top level to select the port-valid and port-pop rules.
package lagd_spin_pkg;

    localparam int unsigned DATASPIN_DEF = 256;

    typedef logic [DATASPIN_DEF-1:0] spin_t;

    localparam logic MODE_LOCKSTEP  = 1'b0;
    localparam logic MODE_DECOUPLED = 1'b1;

endpackage

// File: rtl/spin_broadcast_rdport.sv
// Per-consumer read state: read pointer and unread-word count into the shared store.
// A masked port is held empty and kept aligned with the next write position.
module spin_broadcast_rdport
    import lagd_spin_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1),
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mask_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [PTR_W-1:0] wptr_nxt_i,
    output logic [PTR_W-1:0] rptr_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nonempty_o
);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next pointer/count; a disabled port follows the post-edge write pointer so
    // a push in the same cycle as re-enable lands where this port reads.
    always_comb begin
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            rptr_d = '0;
            cnt_d  = '0;
        end else if (!mask_i) begin
            rptr_d = wptr_nxt_i;
            cnt_d  = '0;
        end else begin
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (pop_i) begin
                rptr_d = rptr_q + PTR_W'(1);
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Port state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rptr_o     = rptr_q;
    assign cnt_o      = cnt_q;
    assign nonempty_o = (cnt_q != CNT_W'(0));

endmodule

// File: rtl/spin_broadcast_buffer.sv
// N-port broadcast buffer: one producer writes a shared store, each enabled
// consumer port reads every word once, in lockstep or independently.
module spin_broadcast_buffer
    import lagd_spin_pkg::*;
#(
    parameter int unsigned DATASPIN = DATASPIN_DEF,
    parameter int unsigned NUM_PORT = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1),
    parameter int unsigned ACC_W    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         mode_i,
    input  logic [NUM_PORT-1:0]          port_mask_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATASPIN-1:0]          spin_i,
    output logic [NUM_PORT-1:0]          out_valid_o,
    input  logic [NUM_PORT-1:0]          out_ready_i,
    output logic [NUM_PORT*DATASPIN-1:0] spin_o,
    output logic [NUM_PORT*CNT_W-1:0]    fill_o,
    output logic [ACC_W-1:0]             acc_cnt_o,
    output logic                         idle_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATASPIN-1:0] store_q [DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [ACC_W-1:0]    acc_cnt_q, acc_cnt_d;

    logic [PTR_W-1:0]    rptr_s [NUM_PORT];
    logic [CNT_W-1:0]    cnt_s  [NUM_PORT];
    logic [NUM_PORT-1:0] nonempty_s, full_vec_s, valid_s, pop_s;
    logic                all_nonempty_s, all_ready_s, full_s, in_ready_s, push_s;

    // Producer handshake and per-port valid/pop; full uses registered counts only.
    always_comb begin
        all_nonempty_s = &(nonempty_s | ~port_mask_i);
        all_ready_s    = &(out_ready_i | ~port_mask_i);
        full_s         = |full_vec_s;
        in_ready_s     = en_i & ~rst_i & ~flush_i & ~full_s;
        push_s         = in_valid_i & in_ready_s;
        valid_s        = '0;
        pop_s          = '0;
        case (mode_i)
            MODE_LOCKSTEP: begin
                valid_s = {NUM_PORT{en_i & ~rst_i & all_nonempty_s}} & port_mask_i;
                pop_s   = valid_s & {NUM_PORT{all_ready_s}};
            end
            MODE_DECOUPLED: begin
                valid_s = {NUM_PORT{en_i & ~rst_i}} & port_mask_i & nonempty_s;
                pop_s   = valid_s & out_ready_i;
            end
            default: begin
                valid_s = '0;
                pop_s   = '0;
            end
        endcase
    end

    // Write pointer and accepted-word counter; flush wins over a push.
    always_comb begin
        if (flush_i) begin
            wptr_d    = '0;
            acc_cnt_d = '0;
        end else if (push_s) begin
            wptr_d    = wptr_q + PTR_W'(1);
            acc_cnt_d = acc_cnt_q + ACC_W'(1);
        end else begin
            wptr_d    = wptr_q;
            acc_cnt_d = acc_cnt_q;
        end
    end

    // Producer-side registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            acc_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // Shared store; contents are never cleared, occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            store_q[wptr_q] <= spin_i;
        end
    end

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
        spin_broadcast_rdport #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W),
            .PTR_W (PTR_W)
        ) u_rdport (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .mask_i     (port_mask_i[p]),
            .flush_i    (flush_i),
            .push_i     (push_s),
            .pop_i      (pop_s[p]),
            .wptr_nxt_i (wptr_d),
            .rptr_o     (rptr_s[p]),
            .cnt_o      (cnt_s[p]),
            .nonempty_o (nonempty_s[p])
        );

        assign full_vec_s[p]                   = port_mask_i[p] & (cnt_s[p] == CNT_W'(DEPTH));
        assign spin_o[p*DATASPIN +: DATASPIN] = store_q[rptr_s[p]];
        assign fill_o[p*CNT_W +: CNT_W]       = cnt_s[p];
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = valid_s;
    assign acc_cnt_o   = acc_cnt_q;
    // Masked ports hold a zero count, so all-counts-zero equals all-enabled-ports-empty.
    assign idle_o      = ~|nonempty_s;

endmodule
